// File: rtl/sim_end_monitor.sv
// Test-completion and performance monitor: watches the fetch PC for tohost writes, counts cycles/instret.
// Timeout detection is compiled in only when SIM_MON_TIMEOUT_EN is defined.
module sim_end_monitor #(
    parameter int NUM_WATCH     = 2,
    parameter int PC_W          = 32,
    parameter int CNT_W         = 64,
    parameter int RET_W         = 2,
    parameter int HIT_THRESHOLD = 2,
    parameter int TIMEOUT_BIT   = 20,
    localparam int CHAN_W       = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PC_W-1:0]           pc_i,
    input  logic                      pc_valid_i,
    input  logic [RET_W-1:0]          retire_cnt_i,
    input  logic [NUM_WATCH*PC_W-1:0] watch_addr_i,
    input  logic [NUM_WATCH-1:0]      watch_en_i,
    input  logic [31:0]               result_i,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [31:0]               fail_num_o,
    output logic [7:0]                hit_cnt_o,
    output logic [CHAN_W-1:0]         hit_chan_o,
    output logic [CNT_W-1:0]          end_cycle_o,
    output logic [CNT_W-1:0]          cycle_o,
    output logic [CNT_W-1:0]          instret_o
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

`ifdef SIM_MON_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [PC_W-1:0]   r_last_pc;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [31:0]       r_fail_num;
    logic [7:0]        r_hit_cnt;
    logic [CHAN_W-1:0] r_hit_chan;
    logic [CNT_W-1:0]  r_end_cycle;
    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_instret;

    logic              w_match;
    logic [CHAN_W-1:0] w_chan;
    logic              w_hit;
    logic [7:0]        w_hit_inc;
    logic              w_complete;
    logic              w_timeout;
    logic              w_adv;
    logic [CNT_W-1:0]  w_cycle_nxt;
    logic [CNT_W:0]    w_instret_sum;
    logic [CNT_W-1:0]  w_instret_nxt;

    // Scan high-to-low so the lowest matching channel is the one reported.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_match = 1'b0;
        w_chan  = '0;
        for (int k = NUM_WATCH - 1; k >= 0; k--) begin
            if (watch_en_i[k] && (watch_addr_i[k*PC_W +: PC_W] == pc_i)) begin
                w_match = 1'b1;
                w_chan  = CHAN_W'(k);
            end
        end
    end

    assign w_hit      = pc_valid_i && w_match && (pc_i != r_last_pc);
    assign w_hit_inc  = (r_hit_cnt == 8'hFF) ? 8'hFF : r_hit_cnt + 8'd1;
    assign w_complete = w_hit && ((r_state == ST_RUN) ? (HIT_THRESHOLD == 1)
                                                      : (w_hit_inc == 8'(HIT_THRESHOLD)));
    assign w_timeout  = TIMEOUT_EN && r_cycle[TIMEOUT_BIT];
    // A timeout edge freezes everything immediately; a completing hit wins the tie.
    assign w_adv      = w_complete || !w_timeout;

    assign w_cycle_nxt   = (&r_cycle) ? r_cycle : r_cycle + CNT_W'(1);
    assign w_instret_sum = {1'b0, r_instret} + (CNT_W + 1)'(retire_cnt_i);
    assign w_instret_nxt = w_instret_sum[CNT_W] ? {CNT_W{1'b1}} : w_instret_sum[CNT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_last_pc   <= '1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_num  <= '0;
            r_hit_cnt   <= '0;
            r_hit_chan  <= '0;
            r_end_cycle <= '0;
            r_cycle     <= '0;
            r_instret   <= '0;
        end else begin
            if (pc_valid_i) r_last_pc <= pc_i;
            if ((r_state == ST_RUN) || (r_state == ST_ARMED)) begin
                if (w_complete) begin
                    r_state    <= ST_DONE;
                    r_done     <= 1'b1;
                    r_pass     <= (result_i == 32'd1);
                    r_fail_num <= result_i;
                end else if (w_timeout) begin
                    r_state   <= ST_TIMEOUT;
                    r_timeout <= 1'b1;
                end else if (w_hit) begin
                    r_state <= ST_ARMED;
                end
                if (w_adv) begin
                    r_cycle   <= w_cycle_nxt;
                    r_instret <= w_instret_nxt;
                    if (w_hit) begin
                        if (r_state == ST_RUN) begin
                            r_hit_cnt   <= 8'd1;
                            r_end_cycle <= r_cycle;
                            r_hit_chan  <= w_chan;
                        end else begin
                            r_hit_cnt <= w_hit_inc;
                        end
                    end
                end
            end
        end
    end

    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign fail_num_o  = r_fail_num;
    assign hit_cnt_o   = r_hit_cnt;
    assign hit_chan_o  = r_hit_chan;
    assign end_cycle_o = r_end_cycle;
    assign cycle_o     = r_cycle;
    assign instret_o   = r_instret;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed self-checking bench for sim_end_monitor (TIMEOUT_BIT=4 so timeouts are reachable quickly).
module tb_sim_end_monitor;

    localparam logic [31:0] TOHOST = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  retire;
    logic [63:0] watch_addr;
    logic [1:0]  watch_en;
    logic [31:0] result;

    logic        done, pass, timeout;
    logic [31:0] fail_num;
    logic [7:0]  hit_cnt;
    logic        hit_chan;
    logic [63:0] end_cycle, cycle, instret;

    int checks   = 0;
    int failures = 0;

    sim_end_monitor #(
        .NUM_WATCH(2), .PC_W(32), .CNT_W(64), .RET_W(2),
        .HIT_THRESHOLD(2), .TIMEOUT_BIT(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .retire_cnt_i(retire),
        .watch_addr_i(watch_addr), .watch_en_i(watch_en), .result_i(result),
        .done_o(done), .pass_o(pass), .timeout_o(timeout), .fail_num_o(fail_num),
        .hit_cnt_o(hit_cnt), .hit_chan_o(hit_chan), .end_cycle_o(end_cycle),
        .cycle_o(cycle), .instret_o(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pc       = '0;
        pc_valid = 1'b0;
        retire   = '0;
        result   = '0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic drive_pc(input logic [31:0] a);
        pc       = a;
        pc_valid = 1'b1;
        step(1);
        pc_valid = 1'b0;
    endtask

    // Hits land at cycle 10 and cycle 12; the second completes the threshold.
    task automatic run_tohost(input logic [31:0] res, input string tag);
        watch_addr = {32'h0, TOHOST};
        watch_en   = 2'b01;
        do_reset();
        result = res;
        step(9);
        check({tag, "_cycle9"}, cycle, 64'd9);
        drive_pc(32'h8000_0000);
        drive_pc(TOHOST);
        check({tag, "_hit1_cnt"}, 64'(hit_cnt), 64'd1);
        check({tag, "_hit1_done"}, 64'(done), 64'd0);
        drive_pc(32'h8000_0044);
        drive_pc(TOHOST);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_pass"}, 64'(pass), (res == 32'd1) ? 64'd1 : 64'd0);
        check({tag, "_fail_num"}, 64'(fail_num), 64'(res));
        check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'd2);
        check({tag, "_end_cycle"}, end_cycle, 64'd10);
        check({tag, "_chan"}, 64'(hit_chan), 64'd0);
        drive_pc(32'h8000_0044);
        drive_pc(TOHOST);
        check({tag, "_frozen_cnt"}, 64'(hit_cnt), 64'd2);
        check({tag, "_frozen_end"}, end_cycle, 64'd10);
        check({tag, "_still_done"}, 64'(done), 64'd1);
        check({tag, "_no_timeout"}, 64'(timeout), 64'd0);
    endtask

    initial begin
        watch_addr = '0;
        watch_en   = '0;
        do_reset();
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_fail_num", 64'(fail_num), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_hit_chan", 64'(hit_chan), 64'd0);
        check("rst_end_cycle", end_cycle, 64'd0);
        check("rst_cycle", cycle, 64'd0);
        check("rst_instret", instret, 64'd0);

        run_tohost(32'd1, "pass");
        run_tohost(32'd5, "fail");

        // Stalled PC: invalid cycles never count, a held valid PC counts once.
        watch_addr = {32'h0, TOHOST};
        watch_en   = 2'b01;
        do_reset();
        pc = TOHOST;
        step(2);
        check("stall_invalid", 64'(hit_cnt), 64'd0);
        pc_valid = 1'b1;
        step(6);
        pc_valid = 1'b0;
        check("stall_cnt", 64'(hit_cnt), 64'd1);
        check("stall_done", 64'(done), 64'd0);

        // Multi-channel match: one hit, lowest enabled channel reported.
        watch_addr = {TOHOST, TOHOST};
        watch_en   = 2'b11;
        do_reset();
        drive_pc(TOHOST);
        check("multi_cnt", 64'(hit_cnt), 64'd1);
        check("multi_chan", 64'(hit_chan), 64'd0);
        check("multi_end", end_cycle, 64'd0);
        watch_en = 2'b10;
        do_reset();
        drive_pc(TOHOST);
        check("chan1_cnt", 64'(hit_cnt), 64'd1);
        check("chan1_chan", 64'(hit_chan), 64'd1);

        // Timeout at cycle bit 4 with no hits.
        watch_en = 2'b00;
        do_reset();
        step(16);
        check("to_cycle16", cycle, 64'd16);
        check("to_before", 64'(timeout), 64'd0);
        step(1);
`ifdef SIM_MON_TIMEOUT_EN
        check("to_set", 64'(timeout), 64'd1);
        check("to_cycle_frozen", cycle, 64'd16);
        step(3);
        check("to_sticky", 64'(timeout), 64'd1);
        check("to_cycle_hold", cycle, 64'd16);
`else
        check("to_off", 64'(timeout), 64'd0);
        check("to_off_cycle", cycle, 64'd17);
        step(3);
        check("to_off_hold", 64'(timeout), 64'd0);
        check("to_off_cycle2", cycle, 64'd20);
`endif
        check("to_no_done", 64'(done), 64'd0);

        // Multi-issue retire count.
        do_reset();
        retire = 2'd2;
        step(5);
        retire = 2'd0;
        check("instret_10", instret, 64'd10);
        check("instret_cycle", cycle, 64'd5);
        step(1);
        check("instret_hold", instret, 64'd10);

        // Reset while ARMED returns to RUN with everything cleared.
        watch_addr = {32'h0, TOHOST};
        watch_en   = 2'b01;
        do_reset();
        result = 32'd7;
        drive_pc(TOHOST);
        check("armed_cnt", 64'(hit_cnt), 64'd1);
        rst    = 1'b1;
        retire = 2'd1;
        step(1);
        check("armrst_cnt", 64'(hit_cnt), 64'd0);
        check("armrst_cycle", cycle, 64'd0);
        check("armrst_instret", instret, 64'd0);
        check("armrst_done", 64'(done), 64'd0);
        rst    = 1'b0;
        retire = 2'd0;
        drive_pc(TOHOST);
        check("armrst_rehit", 64'(hit_cnt), 64'd1);
        check("armrst_not_done", 64'(done), 64'd0);
        check("armrst_cycle1", cycle, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
